axi_lite_manager: RTL
=====================

Name: axi_lite_manager

Overview:
- AXI4-Lite initiator (manager) that converts a simple single-outstanding request/response port into AXI4-Lite read and write transactions.
- Sits between a core-side requester (CPU load/store unit, debug bridge) and the peripheral bus feeding responders such as gpio.
- It is the RTL counterpart of the bus-driving tasks used in peripheral benches, and later replaces them as the stimulus source.

Parameters:
- WIDTH, 32, data width in bits; wstrb width is WIDTH/8.
- ADDR_WIDTH, 32, address width in bits.
- PROT, 3'b000, constant driven on awprot/arprot.

Ports:
- clk  input  1  system clock; the integrator ties axi.aclk to the same net.
- rst_n  input  1  reset, asynchronous, active-low; the integrator ties axi.areset_n to the same net.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when req_valid && req_ready.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  WIDTH  write data.
- req_wstrb  input  WIDTH/8  write byte strobes.
- rsp_valid  output  1  single-cycle completion pulse.
- rsp_rdata  output  WIDTH  read data; valid with rsp_valid on reads.
- rsp_err  output  1  set when resp != 2'b00.
- rsp_resp  output  2  raw bresp/rresp.
- axi  interface  -  axi4_lite master side: aw*, w*, b*, ar*, r* channels.

Behaviour:
- Clock, reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_err = 0.
  - rsp_rdata, rsp_resp, awaddr, araddr, wdata = 0; wstrb = 0.
  - State = IDLE; req_ready = 1 once reset deasserts.
- Outputs: all AXI and rsp outputs are registered. awprot = arprot = PROT.
- One transaction outstanding at a time. req_ready = (state == IDLE).
- States:
  - IDLE: on accept, latch addr/data/strb.
    - If req_write: go to WR_ADDR_DATA and assert awvalid and wvalid together on the next cycle.
    - Else: go to RD_ADDR and assert arvalid.
  - WR_ADDR_DATA: awvalid and wvalid are tracked independently.
    - awvalid deasserts in the cycle after awvalid && awready; same rule for wvalid with wready.
    - Either may complete first, or both in the same cycle.
    - When both handshakes are done: go to WR_RESP and assert bready on the next cycle.
  - WR_RESP: bready = 1.
    - On bvalid: capture bresp and drop bready; rsp_valid = 1 for one cycle next cycle; rsp_err = (bresp != 0); return to IDLE.
  - RD_ADDR: arvalid = 1 until arready, then go to RD_DATA with rready = 1.
  - RD_DATA: on rvalid: capture rdata and rresp, drop rready, pulse rsp_valid, return to IDLE.
- Same-cycle readiness: req_ready is high in the same cycle as the rsp_valid pulse, so back-to-back requests lose no cycles.
- Minimum latency with a zero-wait responder:
  - Write: accept = cycle 0, aw/w valid cycle 1, bready cycle 2, bvalid cycle 2, rsp_valid cycle 3.
  - Read: accept = cycle 0, arvalid cycle 1, rready cycle 2, rvalid cycle 2, rsp_valid cycle 3.
- Valid stability: valid signals never deassert before their ready handshake, and addr/data are held stable while valid (AXI rule).
- Response codes: EXOKAY, SLVERR and DECERR all set rsp_err; rsp_resp reports which one.
- rsp_rdata on writes: holds its previous value.
- Stray responses: bvalid/rvalid arriving outside WR_RESP/RD_DATA are ignored, since bready/rready = 0.
- Requests while busy: req_valid while not in IDLE is not accepted; the requester must hold it.
- Reset mid-transaction: asynchronously clears all valids and readies and returns to IDLE. The in-flight transaction is abandoned and no rsp_valid is issued; the responder must be reset by the same rst_n.

Decomposition:
- Shared axi_lite_pkg:
  - resp_t enum: OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11.
  - manager_state_t enum: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA.
  - Default PROT constant.
- No sub-module: a single FSM with two write-handshake done flags.

Test Plan:
- Write 0xFFFF to gpio MODE (0x0), then write 0xA5C3 to ODATA (0x8) → two rsp_valid pulses with rsp_err = 0; io_pins == 0xA5C3 one cycle later.
- MODE = 0, bench drives pins 0x1234, read IDATA (0x4) → rsp_valid with rsp_rdata = 0x1234, rsp_err = 0; io_pins high-Z before the bench enables its drivers.
- Stub responder asserts awready 3 cycles before wready, then the reverse order, then both in the same cycle → each write completes exactly once, awvalid/wvalid held until their own handshake, bready only after both.
- Stub responder returns bresp = 2'b10, then rresp = 2'b11 → rsp_err = 1 with rsp_resp = 2'b10, then 2'b11.
- Back-to-back requests with req_valid held high (write, read, write) → req_ready high on each rsp_valid cycle; 3 responses in order; zero-wait responder gives a 3-cycle period.
- Assert rst_n low while in WR_RESP with bvalid withheld → awvalid/wvalid/bready drop asynchronously, no rsp_valid; after release, req_ready = 1 and the next read completes normally.

Source files
------------

// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_pkg
//  Description : Shared AXI4-Lite types: response codes, manager FSM states,
//                default protection value and a response-error helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_lite_pkg;

    // AXI4-Lite response encodings carried on bresp/rresp
    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    // Manager transaction sequencing states
    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WR_ADDR_DATA = 3'd1,
        WR_RESP      = 3'd2,
        RD_ADDR      = 3'd3,
        RD_DATA      = 3'd4
    } manager_state_t;

    // Unprivileged, secure, data access
    localparam logic [2:0] c_default_prot = 3'b000;

    // Anything other than OKAY is reported to the requester as an error,
    // including EXOKAY, since a plain requester never asked for exclusivity.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp != OKAY);
    endfunction

endpackage : axi_lite_pkg
`default_nettype wire

// File: rtl/axi_lite_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_if
//  Description : AXI4-Lite bus bundle (AW, W, B, AR, R channels) with
//                master and slave modports.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi_lite_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int WIDTH      = 32
) (
    input logic aclk,
    input logic areset_n
);

    // Write address channel
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    // Write data channel
    logic [WIDTH-1:0]      wdata;
    logic [WIDTH/8-1:0]    wstrb;
    logic                  wvalid;
    logic                  wready;
    // Write response channel
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    // Read address channel
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    // Read data channel
    logic [WIDTH-1:0]      rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        input  aclk, areset_n,
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  aclk, areset_n,
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

endinterface : axi_lite_if
`default_nettype wire

// File: rtl/axi_lite_manager.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_manager
//  Description : AXI4-Lite initiator. Turns a single-outstanding
//                request/response port into AXI4-Lite read and write
//                transactions. All bus and response outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_manager
    import axi_lite_pkg::*;
#(
    parameter int         WIDTH      = 32,
    parameter int         ADDR_WIDTH = 32,
    parameter logic [2:0] PROT       = c_default_prot
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    // Requester side
    input  wire logic                  req_valid,
    output logic                       req_ready,
    input  wire logic                  req_write,
    input  wire logic [ADDR_WIDTH-1:0] req_addr,
    input  wire logic [WIDTH-1:0]      req_wdata,
    input  wire logic [WIDTH/8-1:0]    req_wstrb,
    output logic                       rsp_valid,
    output logic [WIDTH-1:0]           rsp_rdata,
    output logic                       rsp_err,
    output logic [1:0]                 rsp_resp,
    // Bus side
    axi_lite_if.master                 axi
);

    localparam int c_strb_w = WIDTH / 8;

    manager_state_t        r_state;
    // Per-channel completion flags: AW and W may handshake in either order
    logic                  r_aw_done;
    logic                  r_w_done;

    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic                  r_awvalid;
    logic [WIDTH-1:0]      r_wdata;
    logic [c_strb_w-1:0]   r_wstrb;
    logic                  r_wvalid;
    logic                  r_bready;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic                  r_arvalid;
    logic                  r_rready;

    logic                  r_rsp_valid;
    logic [WIDTH-1:0]      r_rsp_rdata;
    logic                  r_rsp_err;
    logic [1:0]            r_rsp_resp;

    logic                  w_accept;
    logic                  w_aw_fire;
    logic                  w_w_fire;
    logic                  w_aw_now;
    logic                  w_w_now;

    // Handshake qualifiers; "now" flags fold in a handshake happening this cycle
    always_comb begin
        w_accept  = req_valid && (r_state == IDLE);
        w_aw_fire = r_awvalid && axi.awready;
        w_w_fire  = r_wvalid && axi.wready;
        w_aw_now  = r_aw_done || w_aw_fire;
        w_w_now   = r_w_done || w_w_fire;
    end

    // Transaction sequencer: owns every registered bus and response output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_awaddr    <= '0;
            r_awvalid   <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_araddr    <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_resp  <= 2'b00;
        end else begin
            // Completion is a one-cycle pulse
            r_rsp_valid <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (req_write) begin
                            r_awaddr  <= req_addr;
                            r_wdata   <= req_wdata;
                            r_wstrb   <= req_wstrb;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                            r_state   <= WR_ADDR_DATA;
                        end else begin
                            r_araddr  <= req_addr;
                            r_arvalid <= 1'b1;
                            r_state   <= RD_ADDR;
                        end
                    end
                end

                WR_ADDR_DATA: begin
                    if (w_aw_fire) begin
                        r_awvalid <= 1'b0;
                    end
                    if (w_w_fire) begin
                        r_wvalid <= 1'b0;
                    end
                    r_aw_done <= w_aw_now;
                    r_w_done  <= w_w_now;
                    // bready only once both address and data are delivered
                    if (w_aw_now && w_w_now) begin
                        r_bready <= 1'b1;
                        r_state  <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    if (axi.bvalid) begin
                        r_bready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_resp  <= axi.bresp;
                        r_rsp_err   <= resp_is_err(axi.bresp);
                        r_aw_done   <= 1'b0;
                        r_w_done    <= 1'b0;
                        r_state     <= IDLE;
                    end
                end

                RD_ADDR: begin
                    if (axi.arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= RD_DATA;
                    end
                end

                RD_DATA: begin
                    if (axi.rvalid) begin
                        r_rready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= axi.rdata;
                        r_rsp_resp  <= axi.rresp;
                        r_rsp_err   <= resp_is_err(axi.rresp);
                        r_state     <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Requester is accepted only while nothing is in flight
    assign req_ready   = (r_state == IDLE);
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_resp    = r_rsp_resp;

    assign axi.awaddr  = r_awaddr;
    assign axi.awprot  = PROT;
    assign axi.awvalid = r_awvalid;
    assign axi.wdata   = r_wdata;
    assign axi.wstrb   = r_wstrb;
    assign axi.wvalid  = r_wvalid;
    assign axi.bready  = r_bready;
    assign axi.araddr  = r_araddr;
    assign axi.arprot  = PROT;
    assign axi.arvalid = r_arvalid;
    assign axi.rready  = r_rready;

endmodule : axi_lite_manager
`default_nettype wire
